// File: rtl/jtframe_sdram64_sched.sv
// Command-bus scheduler for the four-bank SDRAM controller: rotating-priority grant,
// registered pin mux and periodic auto-refresh sequencing.
module jtframe_sdram64_sched #(
    parameter int unsigned RFSH_PER = 750,
    parameter int unsigned TRP      = 2,
    parameter int unsigned TRFC     = 7
) (
    input  logic        rst,
    input  logic        clk,
    input  logic        rfsh_en,
    input  logic [3:0]  br,
    output logic [3:0]  bg,
    input  logic [15:0] bank_cmd,
    input  logic [51:0] bank_a,
    input  logic [3:0]  bank_idle,
    output logic        help,
    output logic        set_prech,
    output logic        rfsh_busy,
    output logic [3:0]  sdram_cmd,
    output logic [12:0] sdram_a,
    output logic [1:0]  sdram_ba
);
    localparam int unsigned CW   = $clog2(RFSH_PER + 1);
    localparam int unsigned WMAX = (TRP > TRFC) ? TRP : TRFC;
    localparam int unsigned WW   = $clog2(WMAX + 1);

    localparam logic [3:0] CMD_NOP   = 4'b0111;
    localparam logic [3:0] CMD_PRECH = 4'b0010;
    localparam logic [3:0] CMD_REF   = 4'b0001;

    typedef enum logic [2:0] {StIdle, StDrain, StPrech, StPwait, StRef, StRwait} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    pend_q, pend_d;
    logic [WW-1:0] wait_q, wait_d;
    logic [1:0]    last_q, last_d;
    logic [3:0]    cmd_d;
    logic [12:0]   a_d;
    logic [1:0]    ba_d;

    logic          gnt_any;
    logic [1:0]    gnt_idx;
    logic [1:0]    idx;
    logic [3:0]    cmd_sel;
    logic [12:0]   a_sel;
    logic          expire;
    logic          dec;

    // Rotating search starting after the last granted bank; k = 4 wraps back to last itself.
    always_comb begin
        gnt_any = 1'b0;
        gnt_idx = last_q;
        idx     = last_q;
        if (!rst && (state_q == StIdle || state_q == StDrain)) begin
            for (int k = 1; k <= 4; k++) begin
                idx = last_q + 2'(k);
                if (!gnt_any && br[idx]) begin
                    gnt_any = 1'b1;
                    gnt_idx = idx;
                end
            end
        end
        bg = gnt_any ? (4'b0001 << gnt_idx) : 4'b0000;
    end

    always_comb begin
        cmd_sel = bank_cmd[3:0];
        a_sel   = bank_a[12:0];
        for (int i = 0; i < 4; i++) begin
            if (gnt_idx == 2'(i)) begin
                cmd_sel = bank_cmd[i*4 +: 4];
                a_sel   = bank_a[i*13 +: 13];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pend_d  = pend_q;
        wait_d  = wait_q;
        last_d  = last_q;
        cmd_d   = CMD_NOP;
        a_d     = sdram_a;
        ba_d    = sdram_ba;
        expire  = rfsh_en && (cnt_q == CW'(RFSH_PER - 1));
        dec     = (state_q == StRef);

        if (rfsh_en) cnt_d = expire ? '0 : cnt_q + 1'b1;

        // Expiry and REF decrement in the same cycle cancel out.
        if (expire && !dec && pend_q != 2'd3) pend_d = pend_q + 2'd1;
        else if (!expire && dec)              pend_d = pend_q - 2'd1;

        if (gnt_any) begin
            last_d = gnt_idx;
            cmd_d  = cmd_sel;
            a_d    = a_sel;
            ba_d   = gnt_idx;
        end

        unique case (state_q)
            StIdle:  if (pend_q != 2'd0) state_d = StDrain;
            StDrain: if (bank_idle == 4'hF && br == 4'h0) state_d = StPrech;
            StPrech: begin
                cmd_d   = CMD_PRECH;
                a_d     = 13'h0400;
                wait_d  = WW'(TRP - 1);
                state_d = StPwait;
            end
            StPwait: begin
                if (wait_q == '0) state_d = StRef;
                else              wait_d  = wait_q - 1'b1;
            end
            StRef: begin
                cmd_d   = CMD_REF;
                wait_d  = WW'(TRFC - 1);
                state_d = StRwait;
            end
            StRwait: begin
                if (wait_q == '0) state_d = (pend_q != 2'd0) ? StRef : StIdle;
                else              wait_d  = wait_q - 1'b1;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            pend_q    <= 2'd0;
            wait_q    <= '0;
            last_q    <= 2'd3;
            sdram_cmd <= CMD_NOP;
            sdram_a   <= 13'h0;
            sdram_ba  <= 2'd0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            pend_q    <= pend_d;
            wait_q    <= wait_d;
            last_q    <= last_d;
            sdram_cmd <= cmd_d;
            sdram_a   <= a_d;
            sdram_ba  <= ba_d;
        end
    end

    assign help      = (state_q != StIdle);
    assign rfsh_busy = (state_q != StIdle);
    assign set_prech = (state_q == StPrech);

endmodule
